except_ctrl: RTL and testbench
==============================

EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 SHALL have parameter N_ISSUE, default 2, issue lanes examined per cycle (1..4).
REQ-002 SHALL have parameter N_INT, default 8, interrupt request lines.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, interrupt synchroniser depth (>=1).
REQ-004 SHALL use a single clock; reset is synchronous and active-high; ports clk, rst.
REQ-005 Ports, in order:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pipe_valid  in  N_ISSUE  lane holds a live instruction
exc_valid  in  N_ISSUE  lane raises an exception
exc_eret  in  N_ISSUE  lane is an ERET
exc_code  in  5*N_ISSUE  per-lane ExcCode
exc_pc  in  32*N_ISSUE  per-lane PC
exc_delayslot  in  N_ISSUE  per-lane delay-slot flag
interrupt_req  in  N_INT  raw asynchronous interrupt lines
status_ie/exl/erl/bev  in  1 each  CP0 Status bits
status_im  in  N_INT  interrupt mask
cause_iv  in  1  Cause.IV
ebase  in  20  EBase[31:12]
epc, error_epc  in  32 each  return targets
mem_busy  in  1  outstanding memory access, must drain first
stall  out  1  freeze pipeline while a request is held
flush  out  1  one-cycle pipeline flush pulse
except_req_valid  out  1  registered exception/ERET request
except_req_eret  out  1  request is ERET
except_req_code  out  5  ExcCode
except_req_pc  out  32  faulting PC
except_req_delayslot  out  1  faulting instr in delay slot
except_vec  out  32  redirect target

Function
REQ-006 interrupt_req SHALL pass through SYNC_STAGES flops; int_pend = |(sync & status_im) & status_ie & ~status_exl & ~status_erl & |pipe_valid.
REQ-007 Lane candidate i = pipe_valid[i] & (exc_valid[i] | exc_eret[i]); the lowest-index candidate SHALL win.
REQ-008 int_pend SHALL beat any lane candidate in the same cycle; it is charged to lane 0: code 0 (INT), pc/delayslot of lane 0, eret 0.
REQ-009 An ERET winner SHALL carry eret=1, code of that lane; an exception winner eret=0.
REQ-010 FSM states IDLE, DRAIN, ISSUE; reset state IDLE.
REQ-011 IDLE: winner exists & mem_busy=0 -> capture winner, go ISSUE; winner & mem_busy=1 -> capture, go DRAIN; else stay.
REQ-012 DRAIN: stall=1; captured winner frozen (new inputs, including new interrupts, ignored); mem_busy=0 -> ISSUE.
REQ-013 ISSUE: exactly one cycle, except_req_valid=1, flush=1, stall=0, fields from captured winner; always -> IDLE.
REQ-014 Latency: winner in cycle N with mem_busy=0 -> except_req_valid in cycle N+1; with drain, cycle after mem_busy first samples 0, +1.
REQ-015 Inputs in the cycle following ISSUE SHALL be evaluated normally (flushed pipeline presents pipe_valid=0).
REQ-016 except_vec for ERET SHALL be error_epc if status_erl else epc, sampled at capture.
REQ-017 Otherwise offset = 0x200 if status_exl=0 & code=INT & cause_iv, else 0x180; vec = 0xBFC00200+offset if status_bev else {ebase, offset[11:0]}; computed at capture.
REQ-018 Outside ISSUE all request outputs and flush SHALL be 0; stall=1 only in DRAIN.
REQ-019 N_ISSUE=1 SHALL reduce to lane-0-only behaviour with identical timing.

Reset
REQ-020 rst in any state (including DRAIN) SHALL force IDLE, clear capture registers and synchroniser flops, and drive all outputs 0 in the following cycle.
REQ-021 No request SHALL issue for an interrupt asserted before rst deasserts until it propagates SYNC_STAGES cycles after reset release.

Verification
REQ-022 Lane1 exc_valid code 0x0C pc 0x80001004, lane0 idle, mem_busy=0, bev=0, ebase=0x80000 -> next cycle valid=1, code=0x0C, pc=0x80001004, vec=0x80000180, flush=1.
REQ-023 Lanes 0 and 1 both exc_valid (codes 0x04, 0x0A) -> code 0x04, lane 0 pc.
REQ-024 interrupt_req[3]=1, im[3]=1, ie=1, iv=1, exl=0, bev=1, held from cycle 0 -> valid in cycle SYNC_STAGES+1, code 0, vec 0xBFC00400; same with im[3]=0 -> never valid.
REQ-025 Exception with mem_busy=1 for 3 cycles -> stall=1 for 3 cycles, no request; valid one cycle after mem_busy falls, fields unchanged.
REQ-026 Lane0 ERET, erl=1, error_epc=0xBFC00380 -> eret=1, vec=0xBFC00380; erl=0, epc=0x80002000 -> vec=0x80002000.
REQ-027 rst asserted during DRAIN -> next cycle stall=0, valid=0, state IDLE; captured request never issued.

Source files
------------

// File: rtl/except_ctrl.sv
// Exception / ERET / interrupt request controller.
// Picks one winner per cycle from the issue lanes (or a pending interrupt),
// optionally waits for outstanding memory traffic to drain, then presents a
// single-cycle registered request with its redirect vector and a flush pulse.
module except_ctrl #(
  parameter int unsigned N_ISSUE     = 2,
  parameter int unsigned N_INT       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_ISSUE-1:0]      pipe_valid,
  input  logic [N_ISSUE-1:0]      exc_valid,
  input  logic [N_ISSUE-1:0]      exc_eret,
  input  logic [5*N_ISSUE-1:0]    exc_code,
  input  logic [32*N_ISSUE-1:0]   exc_pc,
  input  logic [N_ISSUE-1:0]      exc_delayslot,
  input  logic [N_INT-1:0]        interrupt_req,
  input  logic                    status_ie,
  input  logic                    status_exl,
  input  logic                    status_erl,
  input  logic                    status_bev,
  input  logic [N_INT-1:0]        status_im,
  input  logic                    cause_iv,
  input  logic [19:0]             ebase,
  input  logic [31:0]             epc,
  input  logic [31:0]             error_epc,
  input  logic                    mem_busy,
  output logic                    stall,
  output logic                    flush,
  output logic                    except_req_valid,
  output logic                    except_req_eret,
  output logic [4:0]              except_req_code,
  output logic [31:0]             except_req_pc,
  output logic                    except_req_delayslot,
  output logic [31:0]             except_vec
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam logic [4:0] EXC_INT = 5'd0;

  state_t           state;
  state_t           state_nxt;

  logic [N_INT-1:0] sync_q [SYNC_STAGES];
  logic             int_pend;

  logic             win_valid;
  logic             win_eret;
  logic             win_ds;
  logic [4:0]       win_code;
  logic [31:0]      win_pc;
  logic [31:0]      win_vec;
  logic [11:0]      vec_off;

  logic             cap_eret;
  logic             cap_ds;
  logic [4:0]       cap_code;
  logic [31:0]      cap_pc;
  logic [31:0]      cap_vec;

  // Interrupt line synchroniser chain, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= interrupt_req;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign int_pend = (|(sync_q[SYNC_STAGES-1] & status_im)) & status_ie &
                    ~status_exl & ~status_erl & (|pipe_valid);

  // Winner selection: pending interrupt beats lanes; lowest live lane otherwise
  always_comb begin
    win_valid = 1'b0;
    win_eret  = 1'b0;
    win_code  = '0;
    win_pc    = '0;
    win_ds    = 1'b0;
    for (int unsigned i = 0; i < N_ISSUE; i++) begin
      if (!win_valid && pipe_valid[i] && (exc_valid[i] || exc_eret[i])) begin
        win_valid = 1'b1;
        // a lane flagging both an exception and ERET is treated as the exception
        win_eret  = exc_eret[i] & ~exc_valid[i];
        win_code  = exc_code[5*i +: 5];
        win_pc    = exc_pc[32*i +: 32];
        win_ds    = exc_delayslot[i];
      end
    end
    if (int_pend) begin
      win_valid = 1'b1;
      win_eret  = 1'b0;
      win_code  = EXC_INT;
      win_pc    = exc_pc[31:0];
      win_ds    = exc_delayslot[0];
    end
  end

  // Redirect target for the current winner
  always_comb begin
    vec_off = 12'h180;
    win_vec = '0;
    if (win_eret) begin
      win_vec = status_erl ? error_epc : epc;
    end else begin
      if (!status_exl && (win_code == EXC_INT) && cause_iv) vec_off = 12'h200;
      win_vec = status_bev ? (32'hBFC0_0200 + {20'd0, vec_off}) : {ebase, vec_off};
    end
  end

  // Capture registers, loaded only when a winner is accepted from IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_eret <= 1'b0;
      cap_ds   <= 1'b0;
      cap_code <= '0;
      cap_pc   <= '0;
      cap_vec  <= '0;
    end else if ((state == IDLE) && win_valid) begin
      cap_eret <= win_eret;
      cap_ds   <= win_ds;
      cap_code <= win_code;
      cap_pc   <= win_pc;
      cap_vec  <= win_vec;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_valid) state_nxt = mem_busy ? DRAIN : ISSUE;
      DRAIN:   if (!mem_busy) state_nxt = ISSUE;
      ISSUE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: request fields only visible while issuing, stall only while draining
  always_comb begin
    stall                = (state == DRAIN);
    flush                = 1'b0;
    except_req_valid     = 1'b0;
    except_req_eret      = 1'b0;
    except_req_code      = '0;
    except_req_pc        = '0;
    except_req_delayslot = 1'b0;
    except_vec           = '0;
    if (state == ISSUE) begin
      flush                = 1'b1;
      except_req_valid     = 1'b1;
      except_req_eret      = cap_eret;
      except_req_code      = cap_code;
      except_req_pc        = cap_pc;
      except_req_delayslot = cap_ds;
      except_vec           = cap_vec;
    end
  end

endmodule

// File: tb/tb_except_ctrl.sv
// Bench for except_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_except_ctrl;

  localparam int unsigned NI = 2;
  localparam int unsigned NT = 8;
  localparam int unsigned SS = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NI-1:0]     pipe_valid;
  logic [NI-1:0]     exc_valid;
  logic [NI-1:0]     exc_eret;
  logic [5*NI-1:0]   exc_code;
  logic [32*NI-1:0]  exc_pc;
  logic [NI-1:0]     exc_delayslot;
  logic [NT-1:0]     interrupt_req;
  logic              status_ie, status_exl, status_erl, status_bev;
  logic [NT-1:0]     status_im;
  logic              cause_iv;
  logic [19:0]       ebase;
  logic [31:0]       epc, error_epc;
  logic              mem_busy;
  logic              stall, flush, except_req_valid, except_req_eret;
  logic [4:0]        except_req_code;
  logic [31:0]       except_req_pc;
  logic              except_req_delayslot;
  logic [31:0]       except_vec;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  except_ctrl #(.N_ISSUE(NI), .N_INT(NT), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .exc_valid(exc_valid), .exc_eret(exc_eret),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_delayslot(exc_delayslot),
    .interrupt_req(interrupt_req),
    .status_ie(status_ie), .status_exl(status_exl), .status_erl(status_erl),
    .status_bev(status_bev), .status_im(status_im), .cause_iv(cause_iv),
    .ebase(ebase), .epc(epc), .error_epc(error_epc), .mem_busy(mem_busy),
    .stall(stall), .flush(flush), .except_req_valid(except_req_valid),
    .except_req_eret(except_req_eret), .except_req_code(except_req_code),
    .except_req_pc(except_req_pc), .except_req_delayslot(except_req_delayslot),
    .except_vec(except_vec)
  );

  // ---------------- behavioural model ----------------
  bit            m_ready = 1'b0;
  bit            m_wait  = 1'b0;   // request held, memory not yet idle
  bit            m_fire  = 1'b0;   // request shown during this cycle
  bit            m_eret, m_ds;
  logic [4:0]    m_code;
  logic [31:0]   m_pc, m_vec;
  logic [NT-1:0] m_hist[$];        // interrupt samples, newest at front
  bit            w_eret, w_ds;
  logic [4:0]    w_code;
  logic [31:0]   w_pc;

  function automatic bit model_pick(output bit eret, output logic [4:0] code,
                                    output logic [31:0] pc, output bit ds);
    bit intr;
    intr = ((m_hist[SS-1] & status_im) != '0) && status_ie && !status_exl &&
           !status_erl && (pipe_valid != '0);
    eret = 1'b0; code = 5'd0; pc = exc_pc[31:0]; ds = exc_delayslot[0];
    if (intr) return 1'b1;
    for (int i = 0; i < int'(NI); i++) begin
      if (pipe_valid[i] && (exc_valid[i] || exc_eret[i])) begin
        eret = exc_eret[i] && !exc_valid[i];
        code = exc_code[5*i +: 5];
        pc   = exc_pc[32*i +: 32];
        ds   = exc_delayslot[i];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_vec(bit eret, logic [4:0] code);
    logic [31:0] off;
    if (eret) return status_erl ? error_epc : epc;
    off = (!status_exl && code == 5'd0 && cause_iv) ? 32'h200 : 32'h180;
    if (status_bev) return 32'hBFC00200 + off;
    return ({12'd0, ebase} << 12) + off;
  endfunction

  // Model advance on each rising edge using the inputs seen by the DUT
  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1'b1; m_wait = 1'b0; m_fire = 1'b0;
      m_hist = {};
      for (int i = 0; i < int'(SS); i++) m_hist.push_front('0);
    end else if (m_ready) begin
      if (m_fire) begin
        m_fire = 1'b0;
      end else if (m_wait) begin
        if (!mem_busy) begin m_wait = 1'b0; m_fire = 1'b1; end
      end else if (model_pick(w_eret, w_code, w_pc, w_ds)) begin
        m_eret = w_eret; m_code = w_code; m_pc = w_pc; m_ds = w_ds;
        m_vec  = model_vec(w_eret, w_code);
        if (mem_busy) m_wait = 1'b1; else m_fire = 1'b1;
      end
      m_hist.push_front(interrupt_req);
      void'(m_hist.pop_back());
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model
  logic [73:0] exp_v, act_v;
  always @(negedge clk) begin
    if (m_ready) begin
      if (m_fire) exp_v = {1'b1, m_eret, m_code, m_pc, m_ds, m_vec, 1'b0, 1'b1};
      else        exp_v = {1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, m_wait, 1'b0};
      act_v = {except_req_valid, except_req_eret, except_req_code, except_req_pc,
               except_req_delayslot, except_vec, stall, flush};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got %h expected %h", $time, act_v, exp_v);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_valid = '0; exc_valid = '0; exc_eret = '0; exc_code = '0; exc_pc = '0;
    exc_delayslot = '0; interrupt_req = '0; status_ie = 1'b0; status_exl = 1'b0;
    status_erl = 1'b0; status_bev = 1'b0; status_im = '0; cause_iv = 1'b0;
    ebase = 20'h80000; epc = '0; error_epc = '0; mem_busy = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    chk("reset_valid", 32'(except_req_valid), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_flush", 32'(flush), 32'd0);

    // lane 1 exception, lane 0 idle
    pipe_valid = 2'b10; exc_valid = 2'b10; exc_code = {5'h0C, 5'h00};
    exc_pc = {32'h80001004, 32'h00000000};
    tick();
    chk("l1_valid", 32'(except_req_valid), 32'd1);
    chk("l1_code",  32'(except_req_code), 32'h0C);
    chk("l1_pc",    except_req_pc, 32'h80001004);
    chk("l1_vec",   except_vec, 32'h80000180);
    chk("l1_flush", 32'(flush), 32'd1);
    idle_inputs();
    tick();
    chk("l1_one_cycle", 32'(except_req_valid), 32'd0);

    // both lanes: lane 0 wins
    pipe_valid = 2'b11; exc_valid = 2'b11; exc_code = {5'h0A, 5'h04};
    exc_pc = {32'h80000104, 32'h80000100};
    tick();
    chk("prio_code", 32'(except_req_code), 32'h04);
    chk("prio_pc",   except_req_pc, 32'h80000100);
    idle_inputs();
    tick();

    // interrupt held through reset release, unmasked
    rst = 1'b1; interrupt_req = 8'h08; status_im = 8'h08; status_ie = 1'b1;
    cause_iv = 1'b1; status_bev = 1'b1; pipe_valid = 2'b01;
    tick();
    rst = 1'b0;
    for (int c = 0; c <= int'(SS); c++) begin
      chk("int_early", 32'(except_req_valid), 32'd0);
      tick();
    end
    chk("int_valid", 32'(except_req_valid), 32'd1);
    chk("int_code",  32'(except_req_code), 32'd0);
    chk("int_vec",   except_vec, 32'hBFC00400);
    idle_inputs();
    tick();

    // same interrupt, masked
    rst = 1'b1; interrupt_req = 8'h08; status_im = 8'h00; status_ie = 1'b1;
    cause_iv = 1'b1; status_bev = 1'b1; pipe_valid = 2'b01;
    tick();
    rst = 1'b0;
    for (int c = 0; c < int'(SS) + 4; c++) begin
      chk("int_masked", 32'(except_req_valid), 32'd0);
      tick();
    end
    idle_inputs();
    tick();

    // exception while memory busy for three cycles
    pipe_valid = 2'b01; exc_valid = 2'b01; exc_code = {5'h00, 5'h04};
    exc_pc = {32'h0, 32'h80003000}; mem_busy = 1'b1;
    chk("drain_n_stall", 32'(stall), 32'd0);
    tick();
    chk("drain_n1_stall", 32'(stall), 32'd1);
    chk("drain_n1_valid", 32'(except_req_valid), 32'd0);
    exc_code = {5'h00, 5'h08}; exc_pc = {32'h0, 32'h80009999};
    tick();
    chk("drain_n2_stall", 32'(stall), 32'd1);
    tick();
    chk("drain_n3_stall", 32'(stall), 32'd1);
    mem_busy = 1'b0;
    tick();
    chk("drain_valid", 32'(except_req_valid), 32'd1);
    chk("drain_stall", 32'(stall), 32'd0);
    chk("drain_code",  32'(except_req_code), 32'h04);
    chk("drain_pc",    except_req_pc, 32'h80003000);
    chk("drain_vec",   except_vec, 32'h80000180);
    idle_inputs();
    tick();

    // ERET with and without ERL
    pipe_valid = 2'b01; exc_eret = 2'b01; exc_code = {5'h00, 5'h0D};
    status_erl = 1'b1; error_epc = 32'hBFC00380; epc = 32'h80002000;
    tick();
    chk("eret_erl_flag", 32'(except_req_eret), 32'd1);
    chk("eret_erl_vec",  except_vec, 32'hBFC00380);
    chk("eret_erl_code", 32'(except_req_code), 32'h0D);
    pipe_valid = '0;
    tick();
    pipe_valid = 2'b01; status_erl = 1'b0;
    tick();
    chk("eret_epc_flag", 32'(except_req_eret), 32'd1);
    chk("eret_epc_vec",  except_vec, 32'h80002000);
    idle_inputs();
    tick();

    // reset during drain discards the held request
    pipe_valid = 2'b01; exc_valid = 2'b01; exc_code = {5'h00, 5'h05}; mem_busy = 1'b1;
    tick();
    chk("rstdrain_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    tick();
    chk("rstdrain_stall0", 32'(stall), 32'd0);
    chk("rstdrain_valid0", 32'(except_req_valid), 32'd0);
    rst = 1'b0;
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rstdrain_none", 32'(except_req_valid), 32'd0);
    end

    // randomized traffic, checked by the model process
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < int'(NI); i++) begin
        pipe_valid[i]     = ($urandom_range(0, 3) != 0);
        exc_valid[i]      = ($urandom_range(0, 4) == 0);
        exc_eret[i]       = !exc_valid[i] && ($urandom_range(0, 9) == 0);
        exc_code[5*i +: 5] = 5'($urandom);
        exc_pc[32*i +: 32] = $urandom;
        exc_delayslot[i]  = 1'($urandom);
      end
      if ($urandom_range(0, 15) == 0) interrupt_req = NT'($urandom & $urandom & $urandom);
      status_ie  = 1'($urandom);
      status_exl = ($urandom_range(0, 3) == 0);
      status_erl = ($urandom_range(0, 7) == 0);
      status_bev = 1'($urandom);
      status_im  = NT'($urandom);
      cause_iv   = 1'($urandom);
      ebase      = 20'($urandom);
      epc        = $urandom;
      error_epc  = $urandom;
      mem_busy   = ($urandom_range(0, 2) == 0);
      tick();
    end

    rst = 1'b0;
    idle_inputs();
    tick(); tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
